corelet_ctrl: RTL and testbench

- Tile sequencer for the corelet datapath (L0 input FIFO, weight-stationary MAC array, OFIFO, SFU array).
- On `start`, runs one weight-stationary tile in order: flush, weight fetch, weight load, activation fetch, execute, OFIFO drain to PSUM SRAM, then optional SFU pass.
- Sits between the top-level instruction source and the corelet. It drives every corelet control strobe plus the activation/weight SRAM read port and the PSUM SRAM write address.

---
 rtl/corelet_ctrl_if.sv | 44 ++++
 rtl/corelet_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_corelet_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/corelet_ctrl_if.sv
// Control/bus bundle between the corelet tile sequencer (master) and the
// instruction source plus corelet datapath it drives (slave).
interface corelet_ctrl_if #(
    parameter int ADDR_W  = 11,
    parameter int XADDR_W = 11,
    parameter int LEN_W   = 8
);
    logic               start;
    logic [LEN_W-1:0]   num_x;
    logic [XADDR_W-1:0] w_base;
    logic [XADDR_W-1:0] x_base;
    logic [ADDR_W-1:0]  psum_base;
    logic [XADDR_W-1:0] xmem_addr;
    logic               xmem_rd;
    logic               l0_wr;
    logic               l0_rd;
    logic               l0_flush_ptr;
    logic               ld_mode;
    logic               load;
    logic               execute;
    logic               mac_reset;
    logic               ofifo_valid;
    logic               ofifo_rd;
    logic [ADDR_W-1:0]  psum_addr;
    logic               psum_wr;
    logic               sfu_start;
    logic               sfu_active;
    logic               busy;
    logic               done;

    modport master (
        input  start, num_x, w_base, x_base, psum_base, ofifo_valid, sfu_active,
        output xmem_addr, xmem_rd, l0_wr, l0_rd, l0_flush_ptr, ld_mode, load,
               execute, mac_reset, ofifo_rd, psum_addr, psum_wr, sfu_start,
               busy, done
    );

    modport slave (
        output start, num_x, w_base, x_base, psum_base, ofifo_valid, sfu_active,
        input  xmem_addr, xmem_rd, l0_wr, l0_rd, l0_flush_ptr, ld_mode, load,
               execute, mac_reset, ofifo_rd, psum_addr, psum_wr, sfu_start,
               busy, done
    );
endinterface

// File: rtl/corelet_ctrl.sv
// Weight-stationary tile sequencer: flush, weight fetch/load, settle, activation
// fetch, execute, OFIFO drain; SFU pass built only when CORELET_CTRL_SFU_EN is defined.
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int ADDR_W  = 11,
    parameter int XADDR_W = 11,
    parameter int LEN_W   = 8,
    parameter int SETTLE  = 16
) (
    input logic            clk,
    input logic            reset,
    corelet_ctrl_if.master bus
);
    // state    | meaning
    // IDLE     | wait for start        FLUSH    | clear L0 pointers and MAC array
    // W_FETCH  | read col weights      W_LOAD   | shift weights into the array
    // W_SETTLE | let weights settle    X_FETCH  | read num_x activations
    // EXEC     | stream activations    DRAIN    | OFIFO rows to PSUM SRAM
    // SFU      | optional SFU pass     DONE     | completion pulse
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FLUSH    = 4'd1;
    localparam logic [3:0] S_W_FETCH  = 4'd2;
    localparam logic [3:0] S_W_LOAD   = 4'd3;
    localparam logic [3:0] S_W_SETTLE = 4'd4;
    localparam logic [3:0] S_X_FETCH  = 4'd5;
    localparam logic [3:0] S_EXEC     = 4'd6;
    localparam logic [3:0] S_DRAIN    = 4'd7;
    localparam logic [3:0] S_SFU      = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;

`ifdef CORELET_CTRL_SFU_EN
    localparam logic [3:0] S_POST = S_SFU;
`else
    localparam logic [3:0] S_POST = S_DONE;
`endif

    // The array needs at least row+col cycles to flush partial weights.
    localparam int SETTLE_EFF = (SETTLE < row + col) ? (row + col) : SETTLE;
    localparam logic [LEN_W-1:0] COL_LAST    = LEN_W'(col - 1);
    localparam logic [LEN_W-1:0] SETTLE_LAST = LEN_W'(SETTLE_EFF - 1);

    logic [3:0]         state;
    logic [LEN_W-1:0]   tmr;
    logic [LEN_W-1:0]   out_cnt;
    logic [LEN_W-1:0]   num_x_q;
    logic [XADDR_W-1:0] x_base_q;
    logic [ADDR_W-1:0]  psum_base_q;
    logic [XADDR_W-1:0] xptr;
    logic               l0_wr_q;
`ifdef CORELET_CTRL_SFU_EN
    logic               sfu_seen;
`endif

    logic               xmem_rd;
    logic               ofifo_rd;
    logic               sfu_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            tmr         <= '0;
            out_cnt     <= '0;
            num_x_q     <= '0;
            x_base_q    <= '0;
            psum_base_q <= '0;
            xptr        <= '0;
            l0_wr_q     <= 1'b0;
`ifdef CORELET_CTRL_SFU_EN
            sfu_seen    <= 1'b0;
`endif
        end else begin
            l0_wr_q <= xmem_rd;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        num_x_q     <= bus.num_x;
                        x_base_q    <= bus.x_base;
                        psum_base_q <= bus.psum_base;
                        xptr        <= bus.w_base;
                        state       <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    tmr   <= COL_LAST;
                    state <= S_W_FETCH;
                end
                S_W_FETCH: begin
                    xptr <= xptr + 1'b1;
                    if (tmr == '0) begin
                        tmr   <= COL_LAST;
                        state <= S_W_LOAD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_W_LOAD: begin
                    if (tmr == '0) begin
                        tmr   <= SETTLE_LAST;
                        state <= S_W_SETTLE;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_W_SETTLE: begin
                    if (tmr != '0) begin
                        tmr <= tmr - 1'b1;
                    end else if (num_x_q == '0) begin
                        state <= S_POST;
                    end else begin
                        xptr  <= x_base_q;
                        tmr   <= num_x_q - 1'b1;
                        state <= S_X_FETCH;
                    end
                end
                S_X_FETCH: begin
                    xptr <= xptr + 1'b1;
                    if (tmr == '0) begin
                        tmr   <= num_x_q - 1'b1;
                        state <= S_EXEC;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_EXEC: begin
                    if (tmr == '0) begin
                        out_cnt <= '0;
                        state   <= S_DRAIN;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.ofifo_valid) begin
                        out_cnt <= out_cnt + 1'b1;
                        if (out_cnt + 1'b1 == num_x_q) begin
                            state <= S_POST;
                        end
                    end
                end
`ifdef CORELET_CTRL_SFU_EN
                S_SFU: begin
                    // First SFU cycle carries the start pulse; sfu_active is ignored there.
                    if (!sfu_seen) begin
                        sfu_seen <= 1'b1;
                    end else if (!bus.sfu_active) begin
                        sfu_seen <= 1'b0;
                        state    <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        xmem_rd   = (state == S_W_FETCH) || (state == S_X_FETCH);
        ofifo_rd  = (state == S_DRAIN) && bus.ofifo_valid;
`ifdef CORELET_CTRL_SFU_EN
        sfu_start = (state == S_SFU) && !sfu_seen;
`else
        sfu_start = 1'b0;
`endif
    end

    assign bus.xmem_rd      = xmem_rd;
    assign bus.xmem_addr    = xmem_rd ? xptr : '0;
    assign bus.l0_wr        = l0_wr_q;
    assign bus.l0_rd        = (state == S_W_LOAD) || (state == S_EXEC);
    assign bus.l0_flush_ptr = (state == S_FLUSH);
    assign bus.mac_reset    = (state == S_FLUSH);
    assign bus.ld_mode      = (state == S_FLUSH) || (state == S_W_FETCH) ||
                              (state == S_W_LOAD) || (state == S_W_SETTLE);
    assign bus.load         = (state == S_W_LOAD);
    assign bus.execute      = (state == S_EXEC);
    assign bus.ofifo_rd     = ofifo_rd;
    assign bus.psum_wr      = ofifo_rd;
    assign bus.psum_addr    = (state == S_DRAIN) ? (psum_base_q + ADDR_W'(out_cnt)) : '0;
    assign bus.sfu_start    = sfu_start;
    assign bus.busy         = (state != S_IDLE);
    assign bus.done         = (state == S_DONE);

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: scoreboard queues hold expected SRAM read and
// PSUM write addresses; cycle-level checks cover timing, strobes and aborts.
module tb_corelet_ctrl;
    localparam int ADDR_W  = 11;
    localparam int XADDR_W = 11;
    localparam int LEN_W   = 8;
`ifdef CORELET_CTRL_SFU_EN
    localparam int SFU_EXTRA = 7;
`else
    localparam int SFU_EXTRA = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    corelet_ctrl_if #(.ADDR_W(ADDR_W), .XADDR_W(XADDR_W), .LEN_W(LEN_W)) bus ();

    corelet_ctrl #(
        .row(8), .col(8), .ADDR_W(ADDR_W), .XADDR_W(XADDR_W), .LEN_W(LEN_W), .SETTLE(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [XADDR_W-1:0] exp_x[$];
    logic [ADDR_W-1:0]  exp_p[$];
    logic prev_xrd = 1'b0;
    int n_load = 0, n_exec = 0, n_done = 0, n_sfu = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {29'b0, bus.xmem_addr, bus.xmem_rd, bus.l0_wr, bus.l0_rd, bus.l0_flush_ptr,
                bus.ld_mode, bus.load, bus.execute, bus.mac_reset, bus.ofifo_rd,
                bus.psum_addr, bus.psum_wr, bus.sfu_start, bus.busy, bus.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called once per cycle at the falling edge.
    task automatic observe();
        logic [XADDR_W-1:0] ex;
        logic [ADDR_W-1:0]  ep;
        if (bus.xmem_rd) begin
            if (exp_x.size() == 0) chk("xmem_unexpected", bus.xmem_rd, 0);
            else begin
                ex = exp_x.pop_front();
                chk("xmem_addr", bus.xmem_addr, ex);
            end
        end
        chk("l0_wr_delay", bus.l0_wr, prev_xrd);
        prev_xrd = reset ? 1'b0 : bus.xmem_rd;
        chk("psum_wr_eq_rd", bus.psum_wr, bus.ofifo_rd);
        if (bus.psum_wr) begin
            if (exp_p.size() == 0) chk("psum_unexpected", bus.psum_wr, 0);
            else begin
                ep = exp_p.pop_front();
                chk("psum_addr", bus.psum_addr, ep);
            end
        end
        chk("load_exec_excl", bus.load & bus.execute, 0);
        if (bus.load)      n_load++;
        if (bus.execute)   n_exec++;
        if (bus.done)      n_done++;
        if (bus.sfu_start) n_sfu++;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            @(negedge clk);
            observe();
        end
    endtask

    task automatic push_tile(input int nx, input int wb, input int xb, input int pb);
        for (int k = 0; k < 8; k++)  exp_x.push_back(XADDR_W'(wb + k));
        for (int k = 0; k < nx; k++) exp_x.push_back(XADDR_W'(xb + k));
        for (int k = 0; k < nx; k++) exp_p.push_back(ADDR_W'(pb + k));
    endtask

    task automatic kick(input int nx, input int wb, input int xb, input int pb);
        tick();
        bus.start     = 1'b1;
        bus.num_x     = LEN_W'(nx);
        bus.w_base    = XADDR_W'(wb);
        bus.x_base    = XADDR_W'(xb);
        bus.psum_base = ADDR_W'(pb);
        @(negedge clk);
        observe();
        tick();
        // Scramble inputs so only the latched copies can be in use.
        bus.start     = 1'b0;
        bus.num_x     = '1;
        bus.w_base    = XADDR_W'(11'h555);
        bus.x_base    = XADDR_W'(11'h2AA);
        bus.psum_base = ADDR_W'(11'h3C3);
    endtask

    // mode 0: ofifo_valid always 1; mode 1: 1,0,0 pattern in DRAIN, 1 elsewhere.
    // Cycle 0 of the loop is the FLUSH cycle.
    task automatic run_tile(input int nx, input int wb, input int xb, input int pb,
                            input int mode, input int restart_c);
        int  load0, exec0, done0, sfu0;
        int  reads, pd, last_rd, done_cyc, sfu_cyc, sfu_hold, drain_end;
        bit  drain_on;
        load0 = n_load; exec0 = n_exec; done0 = n_done; sfu0 = n_sfu;
        reads = 0; pd = 0; last_rd = -1; done_cyc = -1; sfu_cyc = -1; sfu_hold = 0;
        push_tile(nx, wb, xb, pb);
        kick(nx, wb, xb, pb);
        for (int c = 0; c < 400; c++) begin
            bus.start = (c == restart_c);
            drain_on = (nx > 0) && (n_exec - exec0 == nx) && (reads < nx);
            if (mode == 1) bus.ofifo_valid = drain_on ? (pd % 3 == 0) : 1'b1;
            else           bus.ofifo_valid = 1'b1;
            if (drain_on) pd++;
`ifdef CORELET_CTRL_SFU_EN
            bus.sfu_active = (sfu_hold > 0);
            if (sfu_hold > 0) sfu_hold--;
`else
            bus.sfu_active = 1'b1;
`endif
            @(negedge clk);
            observe();
            chk("ofifo_rd", bus.ofifo_rd, bus.ofifo_valid && drain_on);
            if (bus.ofifo_valid && drain_on) begin
                reads++;
                last_rd = c;
            end
`ifdef CORELET_CTRL_SFU_EN
            if (bus.sfu_start) begin
                sfu_cyc  = c;
                sfu_hold = 5;
            end
`endif
            if (bus.done) begin
                done_cyc = c;
                break;
            end
            tick();
        end
        chk("done_seen", done_cyc >= 0, 1);
        drain_end = (nx == 0) ? 33 : ((mode == 0) ? 33 + 3 * nx : last_rd + 1);
        chk("done_cycle", done_cyc, drain_end + SFU_EXTRA);
`ifdef CORELET_CTRL_SFU_EN
        chk("sfu_cycle", sfu_cyc, drain_end);
        chk("sfu_starts", n_sfu - sfu0, 1);
`else
        chk("sfu_starts", n_sfu - sfu0, 0);
`endif
        bus.start       = 1'b0;
        bus.ofifo_valid = 1'b0;
        bus.sfu_active  = 1'b0;
        tick();
        @(negedge clk);
        observe();
        chk("busy_after_done", bus.busy, 0);
        chk("done_one_cycle", bus.done, 0);
        idle(3);
        chk("load_cycles", n_load - load0, 8);
        chk("exec_cycles", n_exec - exec0, nx);
        chk("done_count", n_done - done0, 1);
        chk("xq_drained", exp_x.size(), 0);
        chk("pq_drained", exp_p.size(), 0);
    endtask

    task automatic abort_in_w_load();
        int load0, done0;
        load0 = n_load; done0 = n_done;
        push_tile(4, 'h010, 'h100, 'h020);
        kick(4, 'h010, 'h100, 'h020);
        bus.ofifo_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            observe();
            tick();
        end
        reset = 1'b1;
        #1;
        chk("abort_outs_zero", all_outs(), 0);
        chk("abort_busy", bus.busy, 0);
        @(negedge clk);
        observe();
        tick();
        tick();
        reset = 1'b0;
        bus.ofifo_valid = 1'b0;
        exp_x.delete();
        exp_p.delete();
        prev_xrd = 1'b0;
        idle(40);
        chk("abort_load_cycles", n_load - load0, 3);
        chk("abort_no_done", n_done - done0, 0);
        chk("abort_idle_busy", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b0;
        bus.start       = 1'b0;
        bus.num_x       = '0;
        bus.w_base      = '0;
        bus.x_base      = '0;
        bus.psum_base   = '0;
        bus.ofifo_valid = 1'b0;
        bus.sfu_active  = 1'b0;
        #1 reset = 1'b1;
        #1;
        chk("reset_outs_zero", all_outs(), 0);
        tick();
        tick();
        reset = 1'b0;
        idle(2);
        chk("idle_busy", bus.busy, 0);

        run_tile(4, 'h010, 'h100, 'h020, 0, -1);
        run_tile(4, 'h010, 'h100, 'h020, 1, -1);
        run_tile(0, 'h030, 'h200, 'h040, 0, -1);
        run_tile(4, 'h010, 'h100, 'h020, 0, 38);
        abort_in_w_load();
        run_tile(2, 'h018, 'h120, 'h060, 0, -1);
        run_tile(3, 'h7FC, 'h7FE, 'h7FE, 0, -1);
        run_tile(5, 'h040, 'h300, 'h100, 1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
